// File: rtl/regfile_ctrl_if.sv
// ============================================================================
//  Module   : regfile_ctrl_if
//  Purpose  : Request, regfile-port and status bundle for regfile_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface regfile_ctrl_if;
    logic       coin_valid;
    logic [1:0] coin_sel;
    logic       clear;
    logic [9:0] douta;
    logic [9:0] doutb;
    logic [3:0] rw;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [9:0] din;
    logic       busy;
    logic       done;
    logic       sat;
    logic       reject;

    // The sequencer is the slave; the front end plus regfile form the master.
    modport slave (
        input  coin_valid, coin_sel, clear, douta, doutb,
        output rw, ra, rb, din, busy, done, sat, reject
    );

    modport master (
        output coin_valid, coin_sel, clear, douta, doutb,
        input  rw, ra, rb, din, busy, done, sat, reject
    );
endinterface

`default_nettype wire

// File: rtl/regfile_ctrl.sv
// ============================================================================
//  Module   : regfile_ctrl
//  Purpose  : Write-side sequencer for the 16x10 vending-machine regfile.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_ctrl #(
    parameter int         AMT_MAX = 999,
    parameter logic [3:0] SCRATCH = 4'hF
) (
    input  wire logic      clk,
    input  wire logic      rst,
    regfile_ctrl_if.slave  rf_if
);

    typedef enum logic [2:0] {
        S_INIT0 = 3'd0,
        S_INIT1 = 3'd1,
        S_INIT2 = 3'd2,
        S_INIT3 = 3'd3,
        S_INIT4 = 3'd4,
        S_IDLE  = 3'd5,
        S_ADD   = 3'd6,
        S_CLR   = 3'd7
    } state_t;

    localparam logic [10:0] c_AMT_MAX = 11'(AMT_MAX);
    localparam logic [3:0]  c_R4      = 4'd4;

    state_t     state_q;
    logic [1:0] sel_q;
    logic       done_q;
    logic       sat_q;
    logic       reject_q;

    logic [10:0] w_sum;
    logic        w_clip;

    assign w_sum  = {1'b0, rf_if.douta} + {1'b0, rf_if.doutb};
    assign w_clip = (w_sum > c_AMT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_INIT0;
            sel_q    <= 2'd0;
            done_q   <= 1'b0;
            sat_q    <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            sat_q    <= 1'b0;
            reject_q <= 1'b0;
            case (state_q)
                S_INIT0: state_q <= S_INIT1;
                S_INIT1: state_q <= S_INIT2;
                S_INIT2: state_q <= S_INIT3;
                S_INIT3: state_q <= S_INIT4;
                S_INIT4: state_q <= S_IDLE;
                S_IDLE: begin
                    // clear wins; a coincident coin is silently dropped
                    if (rf_if.clear) begin
                        state_q <= S_CLR;
                    end else if (rf_if.coin_valid) begin
                        if (rf_if.coin_sel != 2'd3) begin
                            sel_q   <= rf_if.coin_sel;
                            state_q <= S_ADD;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end
                end
                S_ADD: begin
                    done_q  <= 1'b1;
                    sat_q   <= w_clip;
                    state_q <= S_IDLE;
                end
                S_CLR: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_INIT0;
            endcase
        end
    end

    // The regfile writes every edge, so every state must name a safe target.
    always_comb begin
        rf_if.rw  = SCRATCH;
        rf_if.din = 10'd0;
        rf_if.ra  = 4'd0;
        rf_if.rb  = c_R4;
        case (state_q)
            S_INIT0: begin rf_if.rw = 4'd0; rf_if.din = 10'd1;   end
            S_INIT1: begin rf_if.rw = 4'd1; rf_if.din = 10'd10;  end
            S_INIT2: begin rf_if.rw = 4'd2; rf_if.din = 10'd100; end
            S_INIT3: begin rf_if.rw = 4'd3; rf_if.din = 10'd4;   end
            S_INIT4: begin rf_if.rw = c_R4; rf_if.din = 10'd0;   end
            S_ADD: begin
                rf_if.ra  = {2'b00, sel_q};
                rf_if.rw  = c_R4;
                rf_if.din = w_clip ? c_AMT_MAX[9:0] : w_sum[9:0];
            end
            S_CLR: begin rf_if.rw = c_R4; rf_if.din = 10'd0; end
            default: ;
        endcase
    end

    assign rf_if.busy   = (state_q != S_IDLE);
    assign rf_if.done   = done_q;
    assign rf_if.sat    = sat_q;
    assign rf_if.reject = reject_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_ctrl.sv
// ============================================================================
//  Module   : tb_regfile_ctrl
//  Purpose  : Self-checking bench for regfile_ctrl with a regfile and a
//             transaction-level model of the paid amount and status pulses.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_ctrl;

    localparam int         AMT_MAX = 999;
    localparam logic [3:0] SCRATCH = 4'hF;

    logic clk = 1'b0;
    logic rst;

    regfile_ctrl_if bus ();

    regfile_ctrl #(
        .AMT_MAX (AMT_MAX),
        .SCRATCH (SCRATCH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rf_if (bus.slave)
    );

    always #5 clk = ~clk;

    // Regfile: unconditional write every edge, combinational reads
    logic [9:0] rf [16];
    always @(posedge clk) rf[bus.rw] <= bus.din;
    assign bus.douta = rf[bus.ra];
    assign bus.doutb = rf[bus.rb];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int coin_val(input int sel);
        case (sel)
            0: return 1;
            1: return 10;
            default: return 100;
        endcase
    endfunction

    // Model: cycles of busy left, the operation that finishes when it hits 0
    int busy_left = 5;
    int op        = 1;   // 1 init, 2 add, 3 clear
    int op_sel    = 0;
    int m_r4      = 0;
    bit m_known   = 0;
    bit m_done    = 0;
    bit m_sat     = 0;
    bit m_rej     = 0;
    bit scr_ok    = 0;

    always @(posedge clk) begin
        int s;
        m_done = 0; m_sat = 0; m_rej = 0;
        if (rst) begin
            busy_left = 5; op = 1; m_known = 0; scr_ok = 0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                if (op == 1) begin
                    m_r4 = 0; m_known = 1;
                end else if (op == 2) begin
                    s = m_r4 + coin_val(op_sel);
                    m_sat  = (s > AMT_MAX);
                    m_r4   = m_sat ? AMT_MAX : s;
                    m_done = 1;
                end else begin
                    m_r4 = 0; m_done = 1;
                end
            end
        end else begin
            scr_ok = 1;
            if (bus.clear) begin
                busy_left = 1; op = 3;
            end else if (bus.coin_valid && bus.coin_sel != 2'd3) begin
                busy_left = 1; op = 2; op_sel = int'(bus.coin_sel);
            end else if (bus.coin_valid) begin
                m_rej = 1;
            end
        end
    end

    int done_cnt = 0;
    int sat_cnt  = 0;
    int rej_cnt  = 0;
    bit run      = 1;

    always @(negedge clk) begin
        int s;
        if (run) begin
            if (bus.done)   done_cnt++;
            if (bus.sat)    sat_cnt++;
            if (bus.reject) rej_cnt++;
            if (rst) begin
                chk("rst_busy",   int'(bus.busy),   1);
                chk("rst_done",   int'(bus.done),   0);
                chk("rst_sat",    int'(bus.sat),    0);
                chk("rst_reject", int'(bus.reject), 0);
                chk("rst_rw",     int'(bus.rw),     0);
                chk("rst_din",    int'(bus.din),    1);
                chk("rst_ra",     int'(bus.ra),     0);
                chk("rst_rb",     int'(bus.rb),     4);
            end else begin
                chk("busy",   int'(bus.busy),   int'(busy_left > 0));
                chk("done",   int'(bus.done),   int'(m_done));
                chk("sat",    int'(bus.sat),    int'(m_sat));
                chk("reject", int'(bus.reject), int'(m_rej));
                if (busy_left == 0) begin
                    chk("idle_rw",  int'(bus.rw),  int'(SCRATCH));
                    chk("idle_din", int'(bus.din), 0);
                    chk("idle_ra",  int'(bus.ra),  0);
                    chk("idle_rb",  int'(bus.rb),  4);
                end else if (op == 2) begin
                    s = m_r4 + coin_val(op_sel);
                    chk("add_rw",  int'(bus.rw),  4);
                    chk("add_ra",  int'(bus.ra),  op_sel);
                    chk("add_rb",  int'(bus.rb),  4);
                    chk("add_din", int'(bus.din), (s > AMT_MAX) ? AMT_MAX : s);
                end else if (op == 3) begin
                    chk("clr_rw",  int'(bus.rw),  4);
                    chk("clr_din", int'(bus.din), 0);
                end
                if (m_known) begin
                    chk("r0", int'(rf[0]), 1);
                    chk("r1", int'(rf[1]), 10);
                    chk("r2", int'(rf[2]), 100);
                    chk("r3", int'(rf[3]), 4);
                    chk("r4", int'(rf[4]), m_r4);
                end
                if (scr_ok) chk("scratch", int'(rf[SCRATCH]), 0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] sel);
        tick(); bus.coin_valid = 1'b1; bus.coin_sel = sel;
        tick(); bus.coin_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_clear();
        tick(); bus.clear = 1'b1;
        tick(); bus.clear = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int d0, s0, r0;
        rst = 1'b1;
        bus.coin_valid = 1'b0;
        bus.coin_sel   = 2'd0;
        bus.clear      = 1'b0;

        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("init_r0", int'(rf[0]), 1);
        chk("init_r1", int'(rf[1]), 10);
        chk("init_r2", int'(rf[2]), 100);
        chk("init_r3", int'(rf[3]), 4);
        chk("init_r4", int'(rf[4]), 0);
        chk("init_idle", int'(bus.busy), 0);
        repeat (2) tick();

        // Coins 2,1,0,0
        d0 = done_cnt;
        coin(2'd2); chk("coin_100", int'(rf[4]), 100);
        coin(2'd1); chk("coin_110", int'(rf[4]), 110);
        coin(2'd0); chk("coin_111", int'(rf[4]), 111);
        coin(2'd0); chk("coin_112", int'(rf[4]), 112);
        chk("coin_done_cnt", done_cnt - d0, 4);
        chk("coin_sat_cnt",  sat_cnt, 0);

        // Saturation
        do_clear();
        chk("clear_r4", int'(rf[4]), 0);
        s0 = sat_cnt;
        repeat (9) coin(2'd2);
        chk("sat_900", int'(rf[4]), 900);
        chk("sat_none_yet", sat_cnt - s0, 0);
        coin(2'd2);
        chk("sat_999", int'(rf[4]), 999);
        chk("sat_once", sat_cnt - s0, 1);
        coin(2'd2);
        chk("sat_hold", int'(rf[4]), 999);
        chk("sat_twice", sat_cnt - s0, 2);

        // Illegal coin
        d0 = done_cnt; r0 = rej_cnt;
        coin(2'd3);
        chk("rej_cnt",  rej_cnt - r0, 1);
        chk("rej_done", done_cnt - d0, 0);
        chk("rej_r4",   int'(rf[4]), 999);

        // Build 57, then clear and coin together
        do_clear();
        repeat (5) coin(2'd1);
        repeat (7) coin(2'd0);
        chk("r4_57", int'(rf[4]), 57);
        d0 = done_cnt; r0 = rej_cnt;
        tick(); bus.clear = 1'b1; bus.coin_valid = 1'b1; bus.coin_sel = 2'd1;
        tick(); bus.clear = 1'b0; bus.coin_valid = 1'b0;
        tick(); tick();
        chk("both_r4",   int'(rf[4]), 0);
        chk("both_done", done_cnt - d0, 1);
        chk("both_rej",  rej_cnt - r0, 0);

        // Coin while busy is dropped
        d0 = done_cnt;
        tick(); bus.clear = 1'b1;
        tick(); bus.clear = 1'b0; bus.coin_valid = 1'b1; bus.coin_sel = 2'd2;
        tick(); bus.coin_valid = 1'b0;
        tick(); tick();
        chk("busy_r4",   int'(rf[4]), 0);
        chk("busy_done", done_cnt - d0, 1);

        // Reset during ADD
        repeat (5) coin(2'd2);
        chk("r4_500", int'(rf[4]), 500);
        d0 = done_cnt;
        tick(); bus.coin_valid = 1'b1; bus.coin_sel = 2'd2;
        tick(); bus.coin_valid = 1'b0; rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("abort_r4",   int'(rf[4]), 0);
        chk("abort_done", done_cnt - d0, 0);
        chk("abort_idle", int'(bus.busy), 0);
        repeat (2) tick();
        coin(2'd1);
        chk("after_abort", int'(rf[4]), 10);

        run = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
